// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS multicycle control unit:
// state codes (exported on Estado), ALU selector codes, mux encodings,
// and the opcode/funct values the FSM decodes.
package mips_ctrl_pkg;

  typedef enum logic [7:0] {
    S_RESET      = 8'h00,
    S_FETCH      = 8'h01,
    S_FETCH_WAIT = 8'h02,
    S_DECODE     = 8'h03,
    S_R_EXEC     = 8'h04,
    S_R_WB       = 8'h05,
    S_MEM_ADDR   = 8'h06,
    S_LW_READ    = 8'h07,
    S_LW_WAIT    = 8'h08,
    S_LW_WB      = 8'h09,
    S_SW_WRITE   = 8'h0A,
    S_BEQ        = 8'h0B,
    S_BNE        = 8'h0C,
    S_JUMP       = 8'h0D,
    S_ADDI_EXEC  = 8'h0E,
    S_ADDI_WB    = 8'h0F,
    S_EXC_OPC    = 8'h10,
    S_EXC_OVF    = 8'h11,
    S_HALT       = 8'h13
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000,
    ALU_ADD    = 3'b001,
    ALU_SUB    = 3'b010,
    ALU_AND    = 3'b011,
    ALU_XOR    = 3'b110,
    ALU_CMP    = 3'b111
  } alu_op_t;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_BREAK = 6'h0D;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct decoder: picks the ula32 operation and flags whether the
// funct is a supported arithmetic/logic op or the break (halt) encoding.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output alu_op_t    alu_op_o,
  output logic       valid_o,
  output logic       is_break_o
);

  // Unknown functs leave the ALU on pass-A and are reported as invalid.
  always_comb begin
    alu_op_o   = ALU_PASS_A;
    valid_o    = 1'b0;
    is_break_o = 1'b0;
    case (funct_i)
      FN_ADD:   begin alu_op_o = ALU_ADD; valid_o = 1'b1; end
      FN_SUB:   begin alu_op_o = ALU_SUB; valid_o = 1'b1; end
      FN_AND:   begin alu_op_o = ALU_AND; valid_o = 1'b1; end
      FN_XOR:   begin alu_op_o = ALU_XOR; valid_o = 1'b1; end
      FN_BREAK: is_break_o = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mips_control_unit.sv
// Moore multicycle control FSM for the MIPS datapath. Outputs decode the
// current state (plus Funct in R_EXEC and Zero in the branch states).
// Optional build macro MIPS_OVF_EXC_EN: add/sub/addi overflow traps to
// EXC_OVF instead of writing back.
module mips_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT       = 1,
  parameter logic [31:0] EXC_VEC_OPCODE = 32'h0000_00FC,
  parameter logic [31:0] EXC_VEC_OVF    = 32'h0000_00F8
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        Overflow,
  output logic        PC_load,
  output logic [1:0]  PC_src,
  output logic [31:0] ExcVec,
  output logic        IorD,
  output logic        wr,
  output logic        IRWrite,
  output logic        A_load,
  output logic        B_load,
  output logic        MDR_load,
  output logic        AluOut_load,
  output logic        EPC_load,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [7:0]  Estado
);

  // Counter preload: MEM_WAIT=0 still yields a single wait-state cycle.
  localparam logic [2:0] WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  alu_op_t rAluOp;
  logic    rValid;
  logic    rBreak;

  mips_alu_decode u_alu_decode (
    .funct_i   (Funct),
    .alu_op_o  (rAluOp),
    .valid_o   (rValid),
    .is_break_o(rBreak)
  );

  logic ovfTrap;
`ifdef MIPS_OVF_EXC_EN
  assign ovfTrap = Overflow;
`else
  logic unused_overflow;
  assign unused_overflow = Overflow;
  assign ovfTrap = 1'b0;
`endif

  logic isArith;
  assign isArith = (Funct == FN_ADD) || (Funct == FN_SUB);

  // State and wait counter; async reset drops every strobe immediately.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection and memory wait counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET:      state_d = S_FETCH;
      S_FETCH:      begin cnt_d = WAIT_LOAD; state_d = S_FETCH_WAIT; end
      S_FETCH_WAIT: if (cnt_q == 3'd0) state_d = S_DECODE; else cnt_d = cnt_q - 3'd1;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_EXC_OPC;
        endcase
      end
      S_R_EXEC: begin
        if (rBreak)                  state_d = S_HALT;
        else if (!rValid)            state_d = S_EXC_OPC;
        else if (isArith && ovfTrap) state_d = S_EXC_OVF;
        else                         state_d = S_R_WB;
      end
      S_ADDI_EXEC:  state_d = ovfTrap ? S_EXC_OVF : S_ADDI_WB;
      S_MEM_ADDR:   state_d = (Opcode == OP_SW) ? S_SW_WRITE : S_LW_READ;
      S_LW_READ:    begin cnt_d = WAIT_LOAD; state_d = S_LW_WAIT; end
      S_LW_WAIT:    if (cnt_q == 3'd0) state_d = S_LW_WB; else cnt_d = cnt_q - 3'd1;
      S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE,
      S_BEQ, S_BNE, S_JUMP, S_EXC_OPC, S_EXC_OVF:
                    state_d = S_FETCH;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_RESET;
    endcase
  end

  // Output decode: every strobe defaults low, each state raises its own.
  always_comb begin
    PC_load = 1'b0; PC_src = PCSRC_ALU; ExcVec = EXC_VEC_OPCODE;
    IorD = 1'b0; wr = 1'b0; IRWrite = 1'b0;
    A_load = 1'b0; B_load = 1'b0; MDR_load = 1'b0; AluOut_load = 1'b0; EPC_load = 1'b0;
    RegDst = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    ALUSrcA = 1'b0; ALUSrcB = SRCB_B; ALUOp = ALU_PASS_A;
    case (state_q)
      S_RESET: ExcVec = 32'h0;
      S_FETCH_WAIT: begin
        ALUSrcB = SRCB_FOUR; ALUOp = ALU_ADD;
        if (cnt_q == 3'd0) begin IRWrite = 1'b1; PC_load = 1'b1; end
      end
      S_DECODE: begin
        A_load = 1'b1; B_load = 1'b1; AluOut_load = 1'b1;
        ALUSrcB = SRCB_IMM_SHL2; ALUOp = ALU_ADD;
      end
      S_R_EXEC:    begin ALUSrcA = 1'b1; ALUOp = rAluOp; AluOut_load = 1'b1; end
      S_R_WB:      begin RegDst = 1'b1; RegWrite = 1'b1; end
      S_ADDI_EXEC, S_MEM_ADDR: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; ALUOp = ALU_ADD; AluOut_load = 1'b1;
      end
      S_ADDI_WB:   RegWrite = 1'b1;
      S_LW_READ:   IorD = 1'b1;
      S_LW_WAIT:   begin IorD = 1'b1; MDR_load = (cnt_q == 3'd0); end
      S_LW_WB:     begin MemtoReg = 1'b1; RegWrite = 1'b1; end
      S_SW_WRITE:  begin IorD = 1'b1; wr = 1'b1; end
      S_BEQ, S_BNE: begin
        ALUSrcA = 1'b1; ALUOp = ALU_CMP; PC_src = PCSRC_ALUOUT;
        PC_load = (state_q == S_BEQ) ? Zero : !Zero;
      end
      S_JUMP:      begin PC_src = PCSRC_JUMP; PC_load = 1'b1; end
      S_EXC_OPC:   begin
        ALUSrcB = SRCB_FOUR; ALUOp = ALU_SUB; EPC_load = 1'b1;
        PC_src = PCSRC_EXC; PC_load = 1'b1;
      end
`ifdef MIPS_OVF_EXC_EN
      S_EXC_OVF:   begin
        ALUSrcB = SRCB_FOUR; ALUOp = ALU_SUB; EPC_load = 1'b1;
        PC_src = PCSRC_EXC; PC_load = 1'b1; ExcVec = EXC_VEC_OVF;
      end
`endif
      default: ;
    endcase
  end

  assign Estado = state_q;

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit. A second instance with MEM_WAIT=2
// shares the inputs and is only watched during its first fetch.
module tb_mips_control_unit;

  logic        Clk, reset_n;
  logic [5:0]  Opcode, Funct;
  logic        Zero, Overflow;
  logic        PC_load, IorD, wr, IRWrite, A_load, B_load, MDR_load, AluOut_load;
  logic        EPC_load, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  PC_src, ALUSrcB;
  logic [2:0]  ALUOp;
  logic [31:0] ExcVec;
  logic [7:0]  Estado;

  logic        d2PcLoad, d2IorD, d2Wr, d2IRWrite, d2ALoad, d2BLoad, d2MdrLoad, d2AluOutLoad;
  logic        d2EpcLoad, d2RegDst, d2MemtoReg, d2RegWrite, d2ALUSrcA;
  logic [1:0]  d2PcSrc, d2ALUSrcB;
  logic [2:0]  d2ALUOp;
  logic [31:0] d2ExcVec;
  logic [7:0]  d2Estado;

  int total = 0;
  int bad   = 0;

  mips_control_unit dut (
    .Clk(Clk), .reset_n(reset_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Overflow(Overflow), .PC_load(PC_load), .PC_src(PC_src), .ExcVec(ExcVec),
    .IorD(IorD), .wr(wr), .IRWrite(IRWrite), .A_load(A_load), .B_load(B_load),
    .MDR_load(MDR_load), .AluOut_load(AluOut_load), .EPC_load(EPC_load),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Estado(Estado)
  );

  mips_control_unit #(.MEM_WAIT(2)) dut2 (
    .Clk(Clk), .reset_n(reset_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Overflow(Overflow), .PC_load(d2PcLoad), .PC_src(d2PcSrc), .ExcVec(d2ExcVec),
    .IorD(d2IorD), .wr(d2Wr), .IRWrite(d2IRWrite), .A_load(d2ALoad), .B_load(d2BLoad),
    .MDR_load(d2MdrLoad), .AluOut_load(d2AluOutLoad), .EPC_load(d2EpcLoad),
    .RegDst(d2RegDst), .MemtoReg(d2MemtoReg), .RegWrite(d2RegWrite), .ALUSrcA(d2ALUSrcA),
    .ALUSrcB(d2ALUSrcB), .ALUOp(d2ALUOp), .Estado(d2Estado)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic ov);
    Opcode = op; Funct = fn; Zero = z; Overflow = ov;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and check the state code, sampling on the falling edge.
  task automatic stepCheck(input string tag, input logic [7:0] exp);
    @(negedge Clk);
    checkOutput(tag, {24'h0, Estado}, {24'h0, exp});
  endtask

  logic [5:0] fnTab [4];
  logic [2:0] opTab [4];

  initial begin
    fnTab = '{6'h20, 6'h22, 6'h24, 6'h26};
    opTab = '{3'b001, 3'b010, 3'b011, 3'b110};

    reset_n = 1'b0;
    applyStimulus(6'h00, 6'h00, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    checkOutput("rst_estado", {24'h0, Estado}, 32'h0);
    checkOutput("rst_regwrite", {31'h0, RegWrite}, 32'h0);
    checkOutput("rst_pcload", {31'h0, PC_load}, 32'h0);
    checkOutput("rst_d2estado", {24'h0, d2Estado}, 32'h0);
    reset_n = 1'b1;

    // add $3,$1,$2 while dut2 runs its longer fetch
    stepCheck("add_fetch", 8'h01);
    checkOutput("d2_fetch", {24'h0, d2Estado}, 32'h01);
    checkOutput("d2_ir_c1", {31'h0, d2IRWrite}, 32'h0);
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b0);
    stepCheck("add_fwait", 8'h02);
    checkOutput("fw_irwrite", {31'h0, IRWrite}, 32'h1);
    checkOutput("fw_pcload", {31'h0, PC_load}, 32'h1);
    checkOutput("d2_ir_c2", {31'h0, d2IRWrite}, 32'h0);
    stepCheck("add_decode", 8'h03);
    checkOutput("dec_aload", {31'h0, A_load}, 32'h1);
    checkOutput("d2_ir_c3", {31'h0, d2IRWrite}, 32'h1);
    checkOutput("d2_state_c3", {24'h0, d2Estado}, 32'h02);
    stepCheck("add_rexec", 8'h04);
    checkOutput("rexec_aluop", {29'h0, ALUOp}, 32'h1);
    checkOutput("rexec_nowrite", {31'h0, RegWrite}, 32'h0);
    checkOutput("d2_ir_c4", {31'h0, d2IRWrite}, 32'h0);
    stepCheck("add_rwb", 8'h05);
    checkOutput("rwb_regwrite", {31'h0, RegWrite}, 32'h1);
    checkOutput("rwb_regdst", {31'h0, RegDst}, 32'h1);
    stepCheck("add_back", 8'h01);

    // funct -> ALUOp table
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'h00, fnTab[i], 1'b0, 1'b0);
      stepCheck("fn_fw", 8'h02);
      stepCheck("fn_dec", 8'h03);
      stepCheck("fn_exec", 8'h04);
      checkOutput("fn_aluop", {29'h0, ALUOp}, {29'h0, opTab[i]});
      stepCheck("fn_wb", 8'h05);
      stepCheck("fn_back", 8'h01);
    end

    // lw
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
    stepCheck("lw_fw", 8'h02);
    stepCheck("lw_dec", 8'h03);
    stepCheck("lw_addr", 8'h06);
    checkOutput("lw_srcb", {30'h0, ALUSrcB}, 32'h2);
    stepCheck("lw_read", 8'h07);
    checkOutput("lw_iord", {31'h0, IorD}, 32'h1);
    checkOutput("lw_wr", {31'h0, wr}, 32'h0);
    stepCheck("lw_wait", 8'h08);
    checkOutput("lw_mdr", {31'h0, MDR_load}, 32'h1);
    stepCheck("lw_wb", 8'h09);
    checkOutput("lw_regwrite", {31'h0, RegWrite}, 32'h1);
    checkOutput("lw_memtoreg", {31'h0, MemtoReg}, 32'h1);
    stepCheck("lw_back", 8'h01);

    // sw
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
    stepCheck("sw_fw", 8'h02);
    stepCheck("sw_dec", 8'h03);
    stepCheck("sw_addr", 8'h06);
    checkOutput("sw_wr_pre", {31'h0, wr}, 32'h0);
    stepCheck("sw_write", 8'h0A);
    checkOutput("sw_wr", {31'h0, wr}, 32'h1);
    stepCheck("sw_back", 8'h01);
    checkOutput("sw_wr_post", {31'h0, wr}, 32'h0);

    // beq: PC_load follows Zero
    applyStimulus(6'h04, 6'h00, 1'b1, 1'b0);
    stepCheck("beq_fw", 8'h02);
    stepCheck("beq_dec", 8'h03);
    stepCheck("beq", 8'h0B);
    checkOutput("beq_pcsrc", {30'h0, PC_src}, 32'h1);
    checkOutput("beq_aluop", {29'h0, ALUOp}, 32'h7);
    checkOutput("beq_taken", {31'h0, PC_load}, 32'h1);
    Zero = 1'b0; #1;
    checkOutput("beq_not_taken", {31'h0, PC_load}, 32'h0);
    stepCheck("beq_back", 8'h01);

    // bne: reversed
    applyStimulus(6'h05, 6'h00, 1'b1, 1'b0);
    stepCheck("bne_fw", 8'h02);
    stepCheck("bne_dec", 8'h03);
    stepCheck("bne", 8'h0C);
    checkOutput("bne_not_taken", {31'h0, PC_load}, 32'h0);
    Zero = 1'b0; #1;
    checkOutput("bne_taken", {31'h0, PC_load}, 32'h1);
    stepCheck("bne_back", 8'h01);

    // jump
    applyStimulus(6'h02, 6'h00, 1'b0, 1'b0);
    stepCheck("j_fw", 8'h02);
    stepCheck("j_dec", 8'h03);
    stepCheck("j", 8'h0D);
    checkOutput("j_pcsrc", {30'h0, PC_src}, 32'h2);
    checkOutput("j_pcload", {31'h0, PC_load}, 32'h1);
    stepCheck("j_back", 8'h01);

    // addi
    applyStimulus(6'h08, 6'h00, 1'b0, 1'b0);
    stepCheck("addi_fw", 8'h02);
    stepCheck("addi_dec", 8'h03);
    stepCheck("addi_exec", 8'h0E);
    checkOutput("addi_srcb", {30'h0, ALUSrcB}, 32'h2);
    stepCheck("addi_wb", 8'h0F);
    checkOutput("addi_regwrite", {31'h0, RegWrite}, 32'h1);
    checkOutput("addi_regdst", {31'h0, RegDst}, 32'h0);
    stepCheck("addi_back", 8'h01);

    // invalid opcode
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
    stepCheck("exo_fw", 8'h02);
    stepCheck("exo_dec", 8'h03);
    stepCheck("exo", 8'h10);
    checkOutput("exo_epc", {31'h0, EPC_load}, 32'h1);
    checkOutput("exo_aluop", {29'h0, ALUOp}, 32'h2);
    checkOutput("exo_pcsrc", {30'h0, PC_src}, 32'h3);
    checkOutput("exo_vec", ExcVec, 32'h0000_00FC);
    checkOutput("exo_pcload", {31'h0, PC_load}, 32'h1);
    stepCheck("exo_back", 8'h01);

    // invalid funct
    applyStimulus(6'h00, 6'h3F, 1'b0, 1'b0);
    stepCheck("exf_fw", 8'h02);
    stepCheck("exf_dec", 8'h03);
    stepCheck("exf_exec", 8'h04);
    stepCheck("exf", 8'h10);
    stepCheck("exf_back", 8'h01);

    // add with overflow
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b1);
    stepCheck("ovf_fw", 8'h02);
    stepCheck("ovf_dec", 8'h03);
    stepCheck("ovf_exec", 8'h04);
`ifdef MIPS_OVF_EXC_EN
    stepCheck("ovf_trap", 8'h11);
    checkOutput("ovf_vec", ExcVec, 32'h0000_00F8);
    checkOutput("ovf_nowrite", {31'h0, RegWrite}, 32'h0);
`else
    stepCheck("ovf_wb", 8'h05);
    checkOutput("ovf_write", {31'h0, RegWrite}, 32'h1);
`endif
    stepCheck("ovf_back", 8'h01);

    // reset in the middle of a store
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
    stepCheck("rsw_fw", 8'h02);
    stepCheck("rsw_dec", 8'h03);
    stepCheck("rsw_addr", 8'h06);
    stepCheck("rsw_write", 8'h0A);
    checkOutput("rsw_wr", {31'h0, wr}, 32'h1);
    reset_n = 1'b0; #1;
    checkOutput("rsw_wr_drop", {31'h0, wr}, 32'h0);
    checkOutput("rsw_estado", {24'h0, Estado}, 32'h0);
    @(negedge Clk);
    checkOutput("rsw_held", {24'h0, Estado}, 32'h0);
    reset_n = 1'b1;
    stepCheck("rsw_fetch", 8'h01);

    // break -> HALT, held until reset
    applyStimulus(6'h00, 6'h0D, 1'b0, 1'b0);
    stepCheck("halt_fw", 8'h02);
    stepCheck("halt_dec", 8'h03);
    stepCheck("halt_exec", 8'h04);
    stepCheck("halt_enter", 8'h13);
    for (int i = 0; i < 20; i++) stepCheck("halt_hold", 8'h13);
    checkOutput("halt_pcload", {31'h0, PC_load}, 32'h0);
    checkOutput("halt_regwrite", {31'h0, RegWrite}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
